// File: rtl/reg_in_buffer_pkg.sv
// Shared types and defaults for the input-side word buffer.
package reg_in_buffer_pkg;

    // Machine word carried from the outside world into the core.
    typedef logic [7:0] t_data;

    // Default FIFO depth and almost-full threshold for reg_in_buffer.
    localparam int IN_FIFO_DEPTH = 4;
    localparam int IN_FIFO_AFULL = 3;

endpackage : reg_in_buffer_pkg

// File: rtl/reg_in_buffer_if.sv
// Bus bundle for reg_in_buffer: source-side x0 signals, machine-side x1
// handshake, fill-level flags and the sticky overflow status/clear.
interface reg_in_buffer_if
    import reg_in_buffer_pkg::*;
#(
    parameter int DEPTH = IN_FIFO_DEPTH
) ();

    localparam int CW = $clog2(DEPTH) + 1;

    logic          datainvx0;
    t_data         datainx0;
    logic          fullx0;
    logic          afullx0;
    logic          datainvx1;
    t_data         datainx1;
    logic          takex1;
    logic [CW-1:0] countx1;
    logic          ovf;
    logic          clr_ovf;

    // Environment side: drives source words, take and clear.
    modport master (
        output datainvx0,
        output datainx0,
        input  fullx0,
        input  afullx0,
        input  datainvx1,
        input  datainx1,
        output takex1,
        input  countx1,
        input  ovf,
        output clr_ovf
    );

    // Buffer side.
    modport slave (
        input  datainvx0,
        input  datainx0,
        output fullx0,
        output afullx0,
        output datainvx1,
        output datainx1,
        input  takex1,
        output countx1,
        output ovf,
        input  clr_ovf
    );

endinterface : reg_in_buffer_if

// File: rtl/reg_in_buffer_mem.sv
// Storage array for the input buffer: one write port, one combinational
// read port. Contents are deliberately not reset; validity is tracked by
// the pointer/count logic in the parent.
module reg_in_mem
    import reg_in_buffer_pkg::*;
#(
    parameter int DEPTH = IN_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          wen,
    input  logic [AW-1:0] waddr,
    input  t_data         wdata,
    input  logic [AW-1:0] raddr,
    output t_data         rdata
);

    t_data mem_q [DEPTH];

    // Write the addressed slot when enabled.
    always_ff @(posedge clock) begin
        if (wen) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : reg_in_mem

// File: rtl/reg_in_buffer.sv
// Input word buffer: absorbs source words (x0) into a small FIFO and
// presents the oldest one a stage later (x1) on a valid/take handshake.
// The head word lives in its own register so datainx1 never has a
// combinational path from the array or from the inputs.
module reg_in_buffer
    import reg_in_buffer_pkg::*;
#(
    parameter int DEPTH = IN_FIFO_DEPTH,
    parameter int AFULL = IN_FIFO_AFULL
) (
    input  logic            clock,
    input  logic            reset_n,
    reg_in_buffer_if.slave  bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          ovf_q,    ovf_d;
    t_data         head_q,   head_d;

    logic          full;
    logic          not_empty;
    logic          push;
    logic          pop;
    logic          drop;
    logic [PW-1:0] rd_ptr_next;
    t_data         rdata_next;

    assign full      = (count_q == CW'(DEPTH));
    assign not_empty = (count_q != '0);

    // A take against an empty buffer is ignored; a full buffer still accepts
    // a word when the head leaves in the same cycle.
    assign pop  = bus.takex1 & not_empty;
    assign push = bus.datainvx0 & (~full | pop);
    assign drop = bus.datainvx0 & full & ~pop;

    // The word behind the current head, needed when the head is consumed.
    assign rd_ptr_next = rd_ptr_q + PW'(1);

    reg_in_mem #(
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clock (clock),
        .wen   (push),
        .waddr (wr_ptr_q),
        .wdata (bus.datainx0),
        .raddr (rd_ptr_next),
        .rdata (rdata_next)
    );

    // Next-state for pointers, occupancy, sticky overflow and head word.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        head_d   = head_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_next;
        end

        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        // Set wins over clear so a drop in the clearing cycle is not lost.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end

        // The incoming word becomes the head when nothing older survives the
        // edge; otherwise a pop advances to the next stored word. When the
        // buffer drains empty the head simply holds.
        if (push && (count_q == '0 || (pop && count_q == CW'(1)))) begin
            head_d = bus.datainx0;
        end else if (pop && count_q > CW'(1)) begin
            head_d = rdata_next;
        end
    end

    // State registers; reset drops every stored word at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            head_q   <= head_d;
        end
    end

    assign bus.fullx0    = full;
    assign bus.afullx0   = (count_q >= CW'(AFULL));
    assign bus.datainvx1 = not_empty;
    assign bus.datainx1  = head_q;
    assign bus.countx1   = count_q;
    assign bus.ovf       = ovf_q;

endmodule : reg_in_buffer

// File: tb/tb_reg_in_buffer.sv
// Bench for reg_in_buffer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, and a long random run.
module tb_reg_in_buffer;
    import reg_in_buffer_pkg::*;

    localparam int DEPTH = IN_FIFO_DEPTH;
    localparam int AFULL = IN_FIFO_AFULL;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    reg_in_buffer_if #(.DEPTH(DEPTH)) bus ();

    reg_in_buffer #(
        .DEPTH (DEPTH),
        .AFULL (AFULL)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of stored words plus sticky overflow bit.
    t_data m_q[$];
    bit    m_ovf;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            bit m_full, m_pop, m_push;
            m_full = (m_q.size() == DEPTH);
            m_pop  = bus.takex1 && (m_q.size() > 0);
            m_push = bus.datainvx0 && (!m_full || m_pop);
            if (bus.datainvx0 && m_full && !m_pop) m_ovf = 1'b1;
            else if (bus.clr_ovf)                  m_ovf = 1'b0;
            if (m_pop)  void'(m_q.pop_front());
            if (m_push) m_q.push_back(bus.datainx0);
        end
    end

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clock) begin
        check("valid", int'(bus.datainvx1), int'(m_q.size() > 0));
        check("count", int'(bus.countx1), m_q.size());
        check("full",  int'(bus.fullx0),  int'(m_q.size() == DEPTH));
        check("afull", int'(bus.afullx0), int'(m_q.size() >= AFULL));
        check("ovf",   int'(bus.ovf),     int'(m_ovf));
        if (m_q.size() > 0) check("head", int'(bus.datainx1), int'(m_q[0]));
    end

    task automatic step(input bit v, input t_data d, input bit t, input bit c);
        bus.datainvx0 = v;
        bus.datainx0  = d;
        bus.takex1    = t;
        bus.clr_ovf   = c;
        @(posedge clock);
        #1;
    endtask

    t_data vals [4];
    int    pv, pt;

    initial begin
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        bus.datainvx0 = 1'b0;
        bus.datainx0  = '0;
        bus.takex1    = 1'b0;
        bus.clr_ovf   = 1'b0;

        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        check("rst_valid", int'(bus.datainvx1), 0);
        check("rst_count", int'(bus.countx1), 0);
        check("rst_full",  int'(bus.fullx0), 0);
        check("rst_afull", int'(bus.afullx0), 0);
        check("rst_ovf",   int'(bus.ovf), 0);
        check("rst_data",  int'(bus.datainx1), 0);

        // Single word latency and take.
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        check("a5_valid", int'(bus.datainvx1), 1);
        check("a5_data",  int'(bus.datainx1), 8'hA5);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("a5_empty", int'(bus.datainvx1), 0);

        // Fill, flags per level, then drain in order.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, vals[i], 1'b0, 1'b0);
            check("fill_count", int'(bus.countx1), i + 1);
            check("fill_afull", int'(bus.afullx0), int'(i + 1 >= 3));
            check("fill_full",  int'(bus.fullx0),  int'(i + 1 == 4));
        end
        for (int i = 0; i < 4; i++) begin
            check("drain_head", int'(bus.datainx1), int'(vals[i]));
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("drain_count", int'(bus.countx1), 0);

        // Full with simultaneous push and pop.
        for (int i = 0; i < 4; i++) step(1'b1, vals[i], 1'b0, 1'b0);
        check("fpp_head0", int'(bus.datainx1), 8'h11);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        check("fpp_count", int'(bus.countx1), 4);
        check("fpp_head1", int'(bus.datainx1), 8'h22);
        check("fpp_ovf",   int'(bus.ovf), 0);
        for (int i = 0; i < 4; i++) begin
            check("fpp_order", int'(bus.datainx1), (i == 3) ? 8'h55 : int'(vals[i + 1]));
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Overflow set, set-beats-clear, then clear.
        for (int i = 0; i < 4; i++) step(1'b1, vals[i], 1'b0, 1'b0);
        step(1'b1, 8'h66, 1'b0, 1'b0);
        check("ovf_set",   int'(bus.ovf), 1);
        check("ovf_count", int'(bus.countx1), 4);
        step(1'b1, 8'h77, 1'b0, 1'b1);
        check("ovf_setwins", int'(bus.ovf), 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_clr", int'(bus.ovf), 0);
        for (int i = 0; i < 4; i++) begin
            check("ovf_order", int'(bus.datainx1), int'(vals[i]));
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Empty with push and take: no bypass.
        step(1'b1, 8'h99, 1'b1, 1'b0);
        check("nobypass_count", int'(bus.countx1), 1);
        check("nobypass_head",  int'(bus.datainx1), 8'h99);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Random traffic with shifting bias to visit full, empty and middle.
        for (int cyc = 0; cyc < 10000; cyc++) begin
            case ((cyc / 250) % 3)
                0:       begin pv = 80; pt = 30; end
                1:       begin pv = 30; pt = 80; end
                default: begin pv = 60; pt = 60; end
            endcase
            step(bit'($urandom_range(99) < pv), t_data'($urandom),
                 bit'($urandom_range(99) < pt), bit'($urandom_range(49) == 0));
        end

        // Mid-stream reset with three words held and ovf set.
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, t_data'(8'hA1 + i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("pre_rst_count", int'(bus.countx1), 3);
        check("pre_rst_ovf",   int'(bus.ovf), 1);
        bus.takex1 = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_valid", int'(bus.datainvx1), 0);
        check("mid_rst_data",  int'(bus.datainx1), 0);
        check("mid_rst_count", int'(bus.countx1), 0);
        check("mid_rst_afull", int'(bus.afullx0), 0);
        check("mid_rst_ovf",   int'(bus.ovf), 0);
        bus.datainvx0 = 1'b1;
        bus.datainx0  = 8'hEE;
        @(posedge clock);
        #1;
        check("in_rst_count", int'(bus.countx1), 0);
        bus.datainvx0 = 1'b0;
        reset_n = 1'b1;
        step(1'b1, 8'h77, 1'b0, 1'b0);
        check("post_rst_head",  int'(bus.datainx1), 8'h77);
        check("post_rst_count", int'(bus.countx1), 1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("post_rst_empty", int'(bus.datainvx1), 0);

        @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_reg_in_buffer
